fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame buffer between a sample source and an FFT core.
// The producer fills one bank while the consumer streams the other. A bank is
// released only when the core signals completion of the frame read from it.
module fft_frame_ctrl #(
  parameter int unsigned N_PTS = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rstn,       // active-high asynchronous reset
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          fft_valid,
  output logic [DW-1:0] fft_data,
  output logic          fft_last,
  input  logic          fft_ready,
  input  logic          fft_done,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          ovf
);

  localparam int unsigned PtrW = $clog2(N_PTS);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(N_PTS - 1);

  typedef enum logic [1:0] {StIdle, StStream, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]      bank_full_q, bank_full_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            ovf_q, ovf_d;

  logic [DW-1:0] mem_q [2][N_PTS];

  logic wr_fire;
  logic rd_fire;

  // Source is held off while reset is asserted as well as while its bank is full.
  assign in_ready  = !rstn && !bank_full_q[wr_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = fft_valid && fft_ready;
  assign fft_data  = mem_q[rd_bank_q][rd_ptr_q];
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;
  assign ovf       = ovf_q;

  // Sample storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_ptr_q] <= in_data;
    end
  end

  // Producer pointers and the sticky overflow flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    ovf_d     = ovf_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (wr_ptr_q == LastPtr) begin
        wr_bank_d = !wr_bank_q;
      end
    end
    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
    end
  end

  // Consumer FSM plus bank ownership; fill and release can land on one edge.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    bank_full_d = bank_full_q;
    fft_valid   = 1'b0;
    fft_last    = 1'b0;

    if (wr_fire && (wr_ptr_q == LastPtr)) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = StStream;
          rd_ptr_d = '0;
        end
      end
      StStream: begin
        fft_valid = 1'b1;
        fft_last  = (rd_ptr_q == LastPtr);
        if (fft_ready) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          if (rd_ptr_q == LastPtr) begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (fft_done) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
          frame_cnt_d            = frame_cnt_q + 16'd1;
          state_d                = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= StIdle;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      bank_full_q <= 2'b00;
      frame_cnt_q <= 16'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bank_full_q <= bank_full_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // rd_fire is only meaningful in StStream; kept for readability of the handshake.
  logic unused_rd_fire;
  assign unused_rd_fire = rd_fire;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: single frame, backpressure, ping-pong,
// overflow, spurious done and mid-frame reset.
module tb_fft_frame_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        fft_valid;
  logic [31:0] fft_data;
  logic        fft_last;
  logic        fft_ready;
  logic        fft_done;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];

  bit auto_done  = 1'b0;
  bit man_done   = 1'b0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
  int done_cnt   = 0;

  fft_frame_ctrl #(
    .N_PTS(32),
    .DW   (32)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .fft_valid(fft_valid),
    .fft_data (fft_data),
    .fft_last (fft_last),
    .fft_ready(fft_ready),
    .fft_done (fft_done),
    .busy     (busy),
    .frame_cnt(frame_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (off-edge) for a free slot, then presents one sample for one cycle.
  task automatic send(input logic [31:0] v);
    int t = 0;
    in_valid = 1'b0;
    while (!in_ready && t < 400) begin
      step(1);
      t++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    step(1);
    man_done = 1'b0;
  endtask

  task automatic wait_size(input int n);
    int t = 0;
    while (got_data.size() < n && t < 1000) begin
      step(1);
      t++;
    end
  endtask

  task automatic wait_frames(input logic [15:0] n);
    int t = 0;
    while (frame_cnt != n && t < 1000) begin
      step(1);
      t++;
    end
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
  endtask

  // FFT-core side: ready pattern and done pulses, driven 2 time units after the edge.
  initial begin
    fft_ready = 1'b1;
    fft_done  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      fft_done = man_done || (done_cnt == 1);
      if (done_cnt > 0) done_cnt--;
      case (ready_mode)
        0:       fft_ready = 1'b1;
        1:       fft_ready = ~fft_ready;
        default: fft_ready = 1'b0;
      endcase
    end
  end

  // Record every handshake on the falling edge; arm the auto-done delay on last.
  initial begin
    forever begin
      @(negedge clk);
      if (fft_valid === 1'b1 && fft_ready === 1'b1) begin
        got_data.push_back(fft_data);
        got_last.push_back(fft_last);
        if (auto_done && fft_last === 1'b1) done_cnt = 5;
      end
    end
  end

  initial begin
    rstn     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_fft_valid", {31'd0, fft_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    step(2);
    rstn = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single frame, always ready, with first-sample latency
    auto_done = 1'b1;
    clear_q();
    for (int i = 0; i < 32; i++) send(i);
    check("lat_pre_valid", {31'd0, fft_valid}, 32'd0);
    step(1);
    check("lat_post_valid", {31'd0, fft_valid}, 32'd1);
    check("lat_post_data", fft_data, 32'd0);
    wait_frames(16'd1);
    step(1);
    check("single_size", got_data.size(), 32'd32);
    for (int i = 0; i < 32 && i < got_data.size(); i++) begin
      check($sformatf("single_data[%0d]", i), got_data[i], i);
      check($sformatf("single_last[%0d]", i), {31'd0, got_last[i]}, {31'd0, i == 31});
    end
    check("single_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd0);

    // Spurious done while idle
    auto_done = 1'b0;
    pulse_done();
    step(1);
    check("spur_idle_cnt", {16'd0, frame_cnt}, 32'd1);
    check("spur_idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure with a spurious done in the middle of the stream
    ready_mode = 1;
    clear_q();
    for (int i = 0; i < 32; i++) send(100 + i);
    wait_size(10);
    pulse_done();
    wait_size(32);
    step(4);
    check("bp_size", got_data.size(), 32'd32);
    for (int i = 0; i < 32 && i < got_data.size(); i++)
      check($sformatf("bp_data[%0d]", i), got_data[i], 100 + i);
    check("bp_busy_wait", {31'd0, busy}, 32'd1);
    check("spur_stream_cnt", {16'd0, frame_cnt}, 32'd1);
    pulse_done();
    check("bp_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    check("bp_busy", {31'd0, busy}, 32'd0);

    // Ping-pong: 96 continuous samples, done 5 cycles after each last
    ready_mode = 0;
    auto_done  = 1'b1;
    clear_q();
    for (int i = 0; i < 96; i++) send(200 + i);
    wait_frames(16'd5);
    step(1);
    check("pp_size", got_data.size(), 32'd96);
    for (int i = 0; i < 96 && i < got_data.size(); i++)
      check($sformatf("pp_data[%0d]", i), got_data[i], 200 + i);
    check("pp_ovf", {31'd0, ovf}, 32'd0);
    check("pp_frame_cnt", {16'd0, frame_cnt}, 32'd5);

    // Overflow: both banks full, done withheld
    auto_done = 1'b0;
    clear_q();
    for (int i = 0; i < 64; i++) send(300 + i);
    wait_size(32);
    step(2);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_before", {31'd0, ovf}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'd999;
    step(1);
    in_valid = 1'b0;
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check("ovf_busy_wait", {31'd0, busy}, 32'd1);
    pulse_done();
    check("ovf_freed_ready", {31'd0, in_ready}, 32'd1);
    wait_size(64);
    step(2);
    pulse_done();
    wait_frames(16'd7);
    check("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd7);
    check("ovf_size", got_data.size(), 32'd64);
    if (got_data.size() >= 64) begin
      check("ovf_data32", got_data[32], 32'd332);
      check("ovf_data63", got_data[63], 32'd363);
    end
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset in the middle of the second frame
    for (int i = 0; i < 32; i++) send(400 + i);
    for (int i = 0; i < 21; i++) send(500 + i);
    rstn = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_fft_valid", {31'd0, fft_valid}, 32'd0);
    check("mid_rst_fft_last", {31'd0, fft_last}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    step(2);
    rstn = 1'b0;
    #1;
    check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    clear_q();
    auto_done = 1'b1;
    for (int i = 0; i < 32; i++) send(600 + i);
    wait_frames(16'd1);
    step(1);
    check("post_rst_size", got_data.size(), 32'd32);
    for (int i = 0; i < 32 && i < got_data.size(); i++)
      check($sformatf("post_rst_data[%0d]", i), got_data[i], 600 + i);
    check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
